uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Parameterised UART transmit framer. Its frame options match the receiver's: DATA_BITS, optional even/odd parity, and 1 or 2 stop bits.
- Accepts parallel words over a valid/ready handshake into a one-deep holding register. Serialises them LSB-first on tx_out, with bit timing paced by an external baud tick from the baud rate generator.
- Replaces the fixed 8-bit tx_fsm/piso pair wherever the transmit frame must match a parameterised receiver.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- ODD_PARITY, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_tick  in  1  one-clk pulse per bit period (tx_enb)
- tx_data  in  DATA_BITS  word to send; sampled only on acceptance
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; word accepted when tx_valid && tx_ready at a clk edge
- tx_out  out  1  serial line, idle high
- tx_busy  out  1  high while the FSM is outside IDLE
- tx_done  out  1  one-clk pulse when the last stop bit period ends

Behaviour:
- Reset (async, rst_n low): tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding register empty, all counters 0. The line goes high immediately, including mid-frame; a partial frame is discarded.
- Handshake:
  - tx_ready = holding register empty.
  - On acceptance, the holding register is loaded and tx_ready drops on the next edge.
  - tx_ready rises again in the cycle the FSM drains the holding register into the shift register, so a second word may be queued while a frame is on the line.
- Registered outputs: tx_out, tx_busy and tx_done are registered.
- Bit periods: every bit level changes only on a clk edge where baud_tick=1. Each bit lasts exactly one tick interval.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. On baud_tick with holding register full:
    - load shift register and parity from the holding register;
    - clear the holding register;
    - tx_out<=0; go to START.
    - A tick in the same cycle as acceptance does not start the frame; the first start edge is the first tick after the holding register is full.
  - START: on tick, tx_out<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: on tick:
    - if bit_cnt==DATA_BITS-1, go to PARITY (tx_out<=parity) when PARITY_EN, else go to STOP (tx_out<=1, stop_cnt<=0);
    - otherwise shift right, tx_out<=next bit, bit_cnt++.
  - PARITY: on tick, tx_out<=1, stop_cnt<=0, go to STOP.
  - STOP: on tick:
    - if stop_cnt==STOP_BITS-1, pulse tx_done;
      - if the holding register is full, start the next frame back-to-back (drain the holding register, tx_out<=0, go to START), with no extra idle period;
      - otherwise go to IDLE.
    - otherwise stop_cnt++.
- Parity: even = XOR of the data bits (total ones including the parity bit is even); odd = inverted.
- baud_tick outside an active transition has no effect; no tick means no progress.
- tx_valid without tx_ready: the word is held off, with no loss or corruption.
- tx_data changes after acceptance are ignored.
- Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods.
- Counter widths: bit_cnt is clog2(DATA_BITS) bits, stop_cnt is 1 bit.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants;
  - function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS) returning the frame length, shared with the receiver and testbench.
- One sub-module, uart_tx_shifter: parameterised-width load/shift-right register with LSB serial output. FSM and holding register stay in the top module.

Test Plan (baud_tick every 4 clk):
- 8N1, send 0xA5 -> tx_out per tick: 0,1,0,1,0,0,1,0,1,1; tx_done one pulse at the end of the stop bit; tx_busy high for 10 ticks.
- PARITY_EN=1, ODD_PARITY=0, 0xA5 -> parity bit 0. With ODD_PARITY=1 -> parity bit 1. Frame is 11 ticks.
- DATA_BITS=7, PARITY_EN=1, ODD_PARITY=1, STOP_BITS=2, 0x41 -> 0,1,0,0,0,0,0,1,1,1,1.
- Back-to-back: tx_valid held with 0x00 then 0xFF -> second start bit directly after the first stop bit; tx_ready high again during the first frame's START; two tx_done pulses 10 ticks apart.
- Reset mid-frame: rst_n low during data bit 3 -> tx_out=1, tx_ready=1, tx_busy=0 immediately. After release, 0x3C is sent as a clean frame.
- Hold-off: tx_valid high with tx_ready low for 5 cycles, tx_data changing each cycle -> only the word present at acceptance is transmitted. Idle ticks with no data leave tx_out=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing types and helpers for the transmit framer, receiver and bench.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame length in baud periods: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Load/shift-right register presenting its LSB as the serial bit; load wins over shift.
// One-cycle update on load/shift; no flow control, the owner paces it.
module uart_tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_dat,
  output logic         ser
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_dat;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign ser = sh_q[0];

endmodule

// File: rtl/uart_tx_framer.sv
// Parameterised UART transmit framer: one-deep holding register feeding an LSB-first serialiser.
// Line changes one clk after a baud_tick edge; tx_ready low while the holding register is full.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int ODD_PARITY = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int              CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic            PAR_SEL   = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_t            state_q, state_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 drain;
  logic                 sh_load;
  logic                 sh_shift;
  logic                 sh_ser;

  assign tx_ready = !hold_vld_q;

  always_comb begin
    state_d    = state_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_out_d   = tx_out_q;
    tx_done_d  = 1'b0;
    drain      = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;

    if (tx_valid && !hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_dat_d = tx_data;
    end

    if (baud_tick) begin
      unique case (state_q)
        IDLE: drain = hold_vld_q;
        START: begin
          tx_out_d  = sh_ser;
          sh_shift  = 1'b1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_out_d = par_q;
              state_d  = PARITY;
            end else begin
              tx_out_d   = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            // Shifter already advanced, so its LSB is the next data bit.
            tx_out_d  = sh_ser;
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          tx_out_d   = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_done_d = 1'b1;
            if (hold_vld_q) begin
              drain = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Drain is exclusive with acceptance: it only fires while the holding register is full.
    if (drain) begin
      sh_load    = 1'b1;
      par_d      = (^hold_dat_q) ^ PAR_SEL;
      hold_vld_d = 1'b0;
      tx_out_d   = 1'b0;
      state_d    = START;
    end

    tx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  uart_tx_shifter #(.W(DATA_BITS)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_dat (hold_dat_q),
    .ser      (sh_ser)
  );

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for two framer configurations (8N1 and 7O2) sharing one baud tick every 4 clk.
// Accepted words go to a queue; a monitor rebuilds each expected frame from the word and checks the line.
module tb_uart_tx_framer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            baud_tick = 1'b0;
  logic [1:0]      tx_valid;
  logic [1:0][8:0] tx_data;
  logic [1:0]      tx_ready;
  logic [1:0]      tx_out;
  logic [1:0]      tx_busy;
  logic [1:0]      tx_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] d;
    longint     c;
  } acc_t;

  acc_t        accq[2][$];
  longint      cyc = 0;
  longint      p_cyc = -1;
  logic        p_tick = 1'b0;
  bit          mon_act[2];
  int          mon_j[2];
  int          mon_len[2];
  logic [15:0] mon_f[2];
  logic        mon_lvl[2];
  int          tcnt = 0;

  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .ODD_PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  uart_tx_framer #(.DATA_BITS(7), .PARITY_EN(1), .ODD_PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(tx_data[1][6:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  function automatic int dbits(input int i); return (i == 0) ? 8 : 7; endfunction
  function automatic int pen(input int i);   return (i == 0) ? 0 : 1; endfunction
  function automatic int podd(input int i);  return (i == 0) ? 0 : 1; endfunction
  function automatic int pstop(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int flen(input int i);  return 1 + dbits(i) + pen(i) + pstop(i); endfunction

  // Expected line levels, index 0 = start bit; unused tail stays 1 (stop level).
  function automatic logic [15:0] build(input int i, input logic [8:0] d);
    logic [15:0] f;
    int n;
    int ones;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int k = 0; k < dbits(i); k++) begin
      f[n] = d[k];
      ones += int'(d[k]);
      n++;
    end
    if (pen(i) != 0) f[n] = (((ones + podd(i)) % 2) == 1);
    return f;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, i, $time, got, want);
    end
  endtask

  task automatic fail(input string name, input int i);
    checks++;
    errors++;
    $display("FAIL %s inst%0d t=%0t got=timeout want=event", name, i, $time);
  endtask

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % 4;
    baud_tick = (tcnt == 0);
  end

  // Monitor: checks outputs produced by the previous edge, then snapshots inputs for the next edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        accq[i].delete();
        mon_act[i] = 1'b0;
        mon_j[i] = 0;
        mon_lvl[i] = 1'b1;
      end else begin
        if (p_tick) begin
          bit ended;
          bit go;
          ended = 1'b0;
          if (mon_act[i]) begin
            mon_j[i]++;
            if (mon_j[i] < mon_len[i]) begin
              chk("frame_bit", i, 32'(tx_out[i]), 32'(mon_f[i][mon_j[i]]));
              chk("busy_frame", i, 32'(tx_busy[i]), 1);
              chk("done_early", i, 32'(tx_done[i]), 0);
            end else begin
              chk("done_pulse", i, 32'(tx_done[i]), 1);
              mon_act[i] = 1'b0;
              ended = 1'b1;
            end
          end
          if (!mon_act[i]) begin
            go = (accq[i].size() > 0) && (accq[i][0].c < p_cyc);
            chk(go ? "start_bit" : "idle_line", i, 32'(tx_out[i]), 32'(!go));
            if (!ended) chk("done_idle", i, 32'(tx_done[i]), 0);
            if (go) begin
              acc_t a;
              a = accq[i].pop_front();
              mon_f[i] = build(i, a.d);
              mon_len[i] = flen(i);
              mon_act[i] = 1'b1;
              mon_j[i] = 0;
            end
            chk("busy_state", i, 32'(tx_busy[i]), 32'(go));
          end
        end else begin
          chk("line_hold", i, 32'(tx_out[i]), 32'(mon_lvl[i]));
          chk("done_quiet", i, 32'(tx_done[i]), 0);
          chk("busy_hold", i, 32'(tx_busy[i]), 32'(mon_act[i]));
        end
        chk("ready", i, 32'(tx_ready[i]), 32'(accq[i].size() == 0));
        mon_lvl[i] = tx_out[i];
        if (tx_valid[i] && tx_ready[i]) begin
          acc_t a;
          a.d = tx_data[i];
          a.c = cyc;
          accq[i].push_back(a);
        end
      end
    end
    p_tick = baud_tick;
    p_cyc = cyc;
    cyc++;
  end

  // Called just after a posedge; when scramble is set, tx_data changes every held-off cycle.
  task automatic send(input int i, input logic [8:0] d, input bit scramble);
    bit ok;
    ok = 1'b0;
    tx_valid[i] = 1'b1;
    tx_data[i] = d;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = tx_ready[i];
      @(posedge clk);
      #1;
      if (!ok && scramble) tx_data[i] = 9'($urandom);
    end
    tx_valid[i] = 1'b0;
    tx_data[i] = 9'($urandom);
    if (!ok) fail("send_timeout", i);
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (accq[i].size() == 0 && !mon_act[i]) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) fail("idle_timeout", i);
  endtask

  task automatic stim(input int i);
    send(i, (i == 0) ? 9'h0A5 : 9'h041, 1'b0);
    wait_idle(i);
    send(i, 9'h000, 1'b0);
    send(i, 9'h1FF, 1'b0);
    wait_idle(i);
    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(0, 40);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(i, 9'($urandom), 1'b1);
    end
    wait_idle(i);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_tx_out"}, i, 32'(tx_out[i]), 1);
      chk({tag, "_ready"}, i, 32'(tx_ready[i]), 1);
      chk({tag, "_busy"}, i, 32'(tx_busy[i]), 0);
      chk({tag, "_done"}, i, 32'(tx_done[i]), 0);
    end
  endtask

  initial begin
    bit hit;
    tx_valid = '0;
    tx_data = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_state("rst_init");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end

    fork
      stim(0);
      stim(1);
    join

    // Reset while data bit 3 of the 8N1 frame is on the line.
    send(0, 9'h0F0, 1'b0);
    send(1, 9'h05A, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      #2;
      if (mon_act[0] && mon_j[0] == 4) hit = 1'b1;
    end
    if (!hit) fail("reach_data_bit3", 0);
    rst_n = 1'b0;
    #1 check_reset_state("rst_mid");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end

    send(0, 9'h03C, 1'b0);
    send(1, 9'h03C, 1'b0);
    wait_idle(0);
    wait_idle(1);
    repeat (20) begin
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
